pipelined_adder_sub: RTL and testbench
======================================

# pipelined_adder_sub

Parametrised, pipelined ripple-carry adder/subtractor. It is the successor to the 4-bit clocked full adder. The operand width is split into carry segments, and one segment is resolved per pipeline stage. The block accepts one operation per enabled cycle and tracks each operation with a valid bit. It adds a subtract mode, a signed-overflow flag, a pipeline enable (stall) and a synchronous reset. It serves as the arithmetic building block for wider datapaths in the design.

## Interface
Parameters:
- WIDTH, 16, operand and result width in bits.
- SEG_WIDTH, 4, bits resolved per pipeline stage.
- WIDTH must be an integer multiple of SEG_WIDTH; any other value is an elaboration error.
- NUM_STAGES = WIDTH/SEG_WIDTH is derived, not user-set.

Ports:
- Clock  input  1  rising-edge clock; single clock domain.
- Reset  input  1  synchronous, active-high reset.
- En  input  1  pipeline enable; 0 = every register holds.
- in_valid  input  1  operands on A, B, C_in and Sub are valid this cycle.
- A  input  WIDTH  operand A, unsigned or two's-complement.
- B  input  WIDTH  operand B.
- C_in  input  1  carry-in for add; borrow-in for subtract.
- Sub  input  1  0 = A+B+C_in; 1 = A−B−C_in.
- out_valid  output  1  sum, C_out and Overflow carry a new result.
- sum  output  WIDTH  result.
- C_out  output  1  carry-out; for subtract, 1 = no borrow.
- Overflow  output  1  signed overflow of the result.

## Operation
- Subtract is computed as A + ~B + ~C_in; both the B inversion and the carry-in inversion are applied at stage 0.
- Stage s (0..NUM_STAGES−1) adds bits [s·SEG_WIDTH +: SEG_WIDTH] of A and B′ plus the carry registered by stage s−1.
- Stage 0 uses the effective carry-in as its carry.
- Upper operand slices travel through skew registers so they meet their carry in the correct stage.
- Lower result slices travel through de-skew registers so the whole result emerges aligned.
- C_out is the carry out of the MSB segment.
- Overflow = (carry into bit WIDTH−1) XOR (carry out of bit WIDTH−1). It is computed inside the last stage.
- A valid bit accompanies each stage.
- sum, C_out and Overflow update only when a valid slot leaves the last stage. Otherwise they hold their last value.
- Bubbles (in_valid=0) propagate with their valid bit cleared. Their data is don't-care internally and never reaches the outputs.
- There is no back-pressure; the consumer must accept every out_valid pulse.
- SEG_WIDTH = WIDTH is legal and degenerates to a single registered adder.

## Timing
Reset:
- Reset=1 at a rising edge clears every valid bit, sum, C_out and Overflow to 0.
- Reset takes priority over En.
- Operations in flight are discarded; none emerges after reset.

Latency and throughput:
- An operation sampled at edge k with En=1 produces out_valid=1 after exactly NUM_STAGES enabled edges.
- With no stalls this is edge k+NUM_STAGES (4 cycles at the defaults).
- out_valid is a single-cycle pulse per operation.
- Throughput is one operation per enabled cycle.

Stall:
- En=0 freezes all stage registers, valid bits and outputs, including a held out_valid=1.
- in_valid is ignored while En=0.
- Each stalled cycle extends the latency by one.
- Results never drop, duplicate or reorder across a stall.

Simultaneous events:
- Reset and En=0 in the same cycle: reset wins.
- in_valid=1 during reset is discarded.

Width rules:
- Results are modulo 2^WIDTH.
- There is no saturation.

## Test plan
All scenarios use the defaults (WIDTH=16, SEG_WIDTH=4, latency 4).
- Reset held 2 cycles with random inputs -> out_valid=0, sum=0x0000, C_out=0, Overflow=0 throughout, and for 4 cycles after release with in_valid=0.
- Add A=0x0001, B=0x0001, C_in=0 -> 4 cycles later sum=0x0002, C_out=0, Overflow=0. Add 0x0006+0x000A+1 -> sum=0x0011.
- Full carry ripple across all segments: A=0xFFFF, B=0x0001, C_in=0 -> sum=0x0000, C_out=1, Overflow=0. Signed edge: A=0x7FFF, B=0x0001 -> sum=0x8000, C_out=0, Overflow=1.
- Subtract cases:
  - 0x0005−0x0007, C_in=0 -> sum=0xFFFE, C_out=0, Overflow=0.
  - 0x8000−0x0001 -> sum=0x7FFF, C_out=1, Overflow=1.
  - 0x0010−0x0000 with C_in=1 -> sum=0x000F, C_out=1.
- Four back-to-back operations, then En=0 for 3 cycles mid-stream -> four out_valid pulses in issue order, the stalled ones 3 cycles late, outputs frozen during the stall, no loss or duplication.
- Three operations issued, then Reset pulsed one cycle while they are in flight -> out_valid=0 from the next cycle on and none of the three results ever appears. An operation issued after reset returns correctly 4 cycles later.

Source files
------------

// File: rtl/pipelined_adder_sub.sv
// pipelined_adder_sub: segmented ripple-carry adder/subtractor that resolves one carry segment per pipeline stage
module pipelined_adder_sub #(
  parameter int WIDTH     = 16,
  parameter int SEG_WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             En,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             Sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             C_out,
  output logic             Overflow
);
  localparam int NUM_STAGES = WIDTH / SEG_WIDTH;
  localparam int L = NUM_STAGES - 1;
  if (SEG_WIDTH < 1 || WIDTH % SEG_WIDTH != 0) begin : g_bad_width
    $error("WIDTH must be a positive multiple of SEG_WIDTH");
  end
  logic [WIDTH-1:0]   r_a [NUM_STAGES];
  logic [WIDTH-1:0]   r_b [NUM_STAGES];
  logic [WIDTH-1:0]   r_s [NUM_STAGES];
  logic               r_c [NUM_STAGES];
  logic               r_v [NUM_STAGES];
  logic [SEG_WIDTH:0] w_seg [NUM_STAGES];
  logic [WIDTH-1:0]   w_s [NUM_STAGES];
  logic               w_c [NUM_STAGES];
  logic               w_ovf;
  always_comb begin
    for (int s = 0; s < NUM_STAGES; s++) begin
      w_seg[s] = {1'b0, r_a[s][s*SEG_WIDTH +: SEG_WIDTH]} + {1'b0, r_b[s][s*SEG_WIDTH +: SEG_WIDTH]}
               + {{SEG_WIDTH{1'b0}}, r_c[s]};
      w_s[s] = r_s[s];
      w_s[s][s*SEG_WIDTH +: SEG_WIDTH] = w_seg[s][SEG_WIDTH-1:0];
      w_c[s] = w_seg[s][SEG_WIDTH];
    end
  end
  // a^b^sum at the MSB recovers the carry into that bit
  assign w_ovf = r_a[L][WIDTH-1] ^ r_b[L][WIDTH-1] ^ w_s[L][WIDTH-1] ^ w_c[L];
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int s = 0; s < NUM_STAGES; s++) r_v[s] <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      C_out     <= 1'b0;
      Overflow  <= 1'b0;
    end else if (En) begin
      r_v[0] <= in_valid;
      r_a[0] <= A;
      r_b[0] <= Sub ? ~B : B;
      r_c[0] <= C_in ^ Sub;
      r_s[0] <= '0;
      for (int s = 1; s < NUM_STAGES; s++) begin
        r_v[s] <= r_v[s-1];
        r_a[s] <= r_a[s-1];
        r_b[s] <= r_b[s-1];
        r_c[s] <= w_c[s-1];
        r_s[s] <= w_s[s-1];
      end
      out_valid <= r_v[L];
      if (r_v[L]) begin
        sum      <= w_s[L];
        C_out    <= w_c[L];
        Overflow <= w_ovf;
      end
    end
  end
endmodule

// File: tb/tb_pipelined_adder_sub.sv
// tb_pipelined_adder_sub: table-driven vectors with a scoreboard queue, plus stall and reset-in-flight sequences
module tb_pipelined_adder_sub;
  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        c, o;
  } vec_t;
  typedef struct {
    logic [15:0] s;
    logic        c, o;
    int          t;
  } exp_t;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, iv = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        ov, co, of;
  logic [15:0] sm;
  int          checks = 0, failures = 0, en_cnt = 0;
  logic        last_en = 1'b0;
  exp_t        q[$];
  exp_t        last_exp;
  vec_t        tv[$];
  vec_t        sv[4];

  pipelined_adder_sub #(.WIDTH(16), .SEG_WIDTH(4)) dut (
    .Clock(clk), .Reset(rst), .En(en), .in_valid(iv), .A(a), .B(b), .C_in(cin), .Sub(sub),
    .out_valid(ov), .sum(sm), .C_out(co), .Overflow(of)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    last_en <= en & ~rst;
    if (en && !rst) en_cnt <= en_cnt + 1;
  end

  function automatic vec_t mk(logic [15:0] x, logic [15:0] y, logic ci, logic sb);
    vec_t v;
    logic [15:0] bb;
    logic [16:0] r;
    bb = sb ? ~y : y;
    r = {1'b0, x} + {1'b0, bb} + 17'(ci ^ sb);
    v.a = x; v.b = y; v.cin = ci; v.sub = sb;
    v.s = r[15:0];
    v.c = r[16];
    v.o = (x[15] == bb[15]) && (r[15] != x[15]);
    return v;
  endfunction

  function automatic vec_t fixed(logic [15:0] x, logic [15:0] y, logic ci, logic sb,
                                 logic [15:0] es, logic ec, logic eo);
    vec_t v;
    v.a = x; v.b = y; v.cin = ci; v.sub = sb; v.s = es; v.c = ec; v.o = eo;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  task automatic issue(vec_t v);
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b1; iv = 1'b1; a = v.a; b = v.b; cin = v.cin; sub = v.sub;
    q.push_back('{v.s, v.c, v.o, en_cnt + 1});
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
      iv = 1'b0; a = 16'($urandom); b = 16'($urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); n++;
    end
    @(negedge clk);
    chk("drain_queue_empty", 32'(q.size()), 0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (ov && last_en) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 32'(ov), 0);
        end else begin
          e = q.pop_front();
          last_exp = e;
          chk("sum", 32'(sm), 32'(e.s));
          chk("c_out", 32'(co), 32'(e.c));
          chk("overflow", 32'(of), 32'(e.o));
          chk("latency", 32'(en_cnt), 32'(e.t + 4));
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    tv.push_back(fixed(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0));
    tv.push_back(fixed(16'h0006, 16'h000A, 1'b1, 1'b0, 16'h0011, 1'b0, 1'b0));
    tv.push_back(fixed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0));
    tv.push_back(fixed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1));
    tv.push_back(fixed(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0));
    tv.push_back(fixed(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1));
    tv.push_back(fixed(16'h0010, 16'h0000, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0));
    for (int i = 0; i < 12; i++)
      tv.push_back(mk(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom)));
    for (int i = 0; i < 4; i++)
      sv[i] = mk(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    fork monitor(); join_none
    // reset held with random inputs
    for (int i = 0; i < 2; i++) begin
      iv = 1'($urandom); en = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
      @(negedge clk);
      chk("rst_out_valid", 32'(ov), 0);
      chk("rst_sum", 32'(sm), 0);
      chk("rst_c_out", 32'(co), 0);
      chk("rst_overflow", 32'(of), 0);
    end
    #1 rst = 1'b0; en = 1'b1; iv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_out_valid", 32'(ov), 0);
      chk("post_rst_sum", 32'(sm), 0);
    end
    // back-to-back table vectors
    foreach (tv[i]) issue(tv[i]);
    idle(1);
    drain();
    // four ops, then a 3-cycle stall while op1 is presented
    for (int i = 0; i < 4; i++) issue(sv[i]);
    idle(2);
    @(posedge clk); #1;
    en = 1'b0; iv = 1'b1; a = 16'($urandom); b = 16'($urandom);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_out_valid_held", 32'(ov), 1);
      chk("stall_sum_frozen", 32'(sm), 32'(sv[1].s));
      chk("stall_c_out_frozen", 32'(co), 32'(sv[1].c));
    end
    #1 en = 1'b1; iv = 1'b0;
    drain();
    // reset while three ops are in flight
    for (int i = 0; i < 3; i++) issue(mk(16'($urandom), 16'($urandom), 1'b0, 1'b0));
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b0; iv = 1'b1; a = 16'($urandom);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b1; iv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("flush_out_valid", 32'(ov), 0);
    end
    issue(mk(16'h1234, 16'h0F0F, 1'b1, 1'b1));
    idle(1);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
